// File: rtl/rv_ex_pkg.sv
// rv_ex_pkg: shared definitions for the RV32I execute stage.
//   - ALU operation codes (4 bits, carried in ID_EX_AluOp)
//   - branch funct3 condition codes
//   - forwarding-select codes for the operand muxes
//   - multiplier FSM state encoding
//   - is_mul_op(): classifies the MUL-class ALU ops
package rv_ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_SLL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_SLTU  = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_OR    = 4'h8;
  localparam logic [3:0] ALU_AND   = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;
  localparam logic [3:0] ALU_MUL   = 4'hB;
  localparam logic [3:0] ALU_MULH  = 4'hC;
  localparam logic [3:0] ALU_MULHU = 4'hD;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier for MUL / MULH / MULHU.
// Operands are captured at issue (magnitudes plus a sign flag for MULH), one
// multiplier bit is consumed per BUSY cycle, and the corrected product is
// presented while in DONE. mem_stall freezes everything; ex_flush aborts.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_req    valid MUL-class op sitting in EX and not being flushed
//   op           ALU op code (selects signedness and result half)
//   a, b         forwarded operands
//   mem_stall    freeze the FSM and datapath
//   ex_flush     return to IDLE, discarding any op in flight
//   busy         hold the front end (IDLE with a request, or BUSY)
//   result       low or high product half, meaningful in DONE
module ex_mul_iter
  import rv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_req,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mem_stall,
  input  logic            ex_flush,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  mul_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic            hi_q, hi_d;

  logic            signed_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s;
  logic [PW-1:0]   prod_fix_s;

  // Only MULH treats operands as signed; MUL's low half is sign-agnostic.
  assign signed_s = (op == ALU_MULH);
  assign abs_a_s  = (signed_s && a[XLEN-1]) ? ({XLEN{1'b0}} - a) : a;
  assign abs_b_s  = (signed_s && b[XLEN-1]) ? ({XLEN{1'b0}} - b) : b;

  assign prod_fix_s = neg_q ? ({PW{1'b0}} - prod_q) : prod_q;
  assign result     = hi_q ? prod_fix_s[PW-1:XLEN] : prod_fix_s[XLEN-1:0];
  assign busy       = ((state_q == MUL_IDLE) && start_req) || (state_q == MUL_BUSY);

  // Next-state and shift-add datapath; flush beats stall beats normal progress.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    if (ex_flush) begin
      state_d = MUL_IDLE;
      cnt_d   = {CW{1'b0}};
    end else if (mem_stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_req) begin
            state_d  = MUL_BUSY;
            cnt_d    = {CW{1'b0}};
            prod_d   = {PW{1'b0}};
            mcand_d  = {{XLEN{1'b0}}, abs_a_s};
            mplier_d = abs_b_s;
            neg_d    = signed_s && (a[XLEN-1] ^ b[XLEN-1]);
            hi_d     = (op != ALU_MUL);
          end else begin
            state_d = MUL_IDLE;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end else begin
            prod_d = prod_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_d = MUL_DONE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = MUL_BUSY;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  // Multiplier state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {PW{1'b0}};
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
// Forwards both operands, runs the ALU, resolves branches/jumps (combinational
// redirect) and owns the EX/MEM register. Build option: RV_MUL_EN adds the
// iterative multiplier (ex_mul_iter) that holds the front end via ex_busy;
// without it MUL-class ops give 0 and ex_busy is 0.
// Ports:
//   ID_EX_*            instruction, operands and control from ID/EX
//   Mux_A, Mux_B       forwarding selects; MEM_WB_WriteData is the WB source
//   mem_stall/ex_flush freeze EX/MEM / kill the instruction in EX
//   EX_MEM_*           EX/MEM pipeline register outputs
//   br_taken/br_target redirect request
//   ex_busy            hold IF, ID and ID/EX
module ex_stage
  import rv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_EX_Valid,
  input  logic [XLEN-1:0] ID_EX_Pc,
  input  logic [XLEN-1:0] ID_EX_Rs1Data,
  input  logic [XLEN-1:0] ID_EX_Rs2Data,
  input  logic [XLEN-1:0] ID_EX_Imm,
  input  logic [3:0]      ID_EX_AluOp,
  input  logic            ID_EX_AluSrcA,
  input  logic            ID_EX_AluSrcB,
  input  logic            ID_EX_Branch,
  input  logic            ID_EX_Jal,
  input  logic            ID_EX_Jalr,
  input  logic [2:0]      ID_EX_BrCond,
  input  logic            ID_EX_RegW,
  input  logic            ID_EX_MemR,
  input  logic            ID_EX_MemW,
  input  logic            ID_EX_MemToReg,
  input  logic [4:0]      ID_EX_RegRd,
  input  logic [1:0]      Mux_A,
  input  logic [1:0]      Mux_B,
  input  logic [XLEN-1:0] MEM_WB_WriteData,
  input  logic            mem_stall,
  input  logic            ex_flush,
  output logic [XLEN-1:0] EX_MEM_AluResult,
  output logic [XLEN-1:0] EX_MEM_Rs2Data,
  output logic [4:0]      EX_MEM_RegRd,
  output logic            EX_MEM_RegW,
  output logic            EX_MEM_MemR,
  output logic            EX_MEM_MemW,
  output logic            EX_MEM_MemToReg,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            ex_busy
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a_s, fwd_b_s, opa_s, opb_s;
  logic [XLEN-1:0] alu_res_s, ex_res_s, mul_res_s, jalr_sum_s;
  logic [SW-1:0]   shamt_s;
  logic            ex_busy_s;

  logic [XLEN-1:0] alu_res_q, alu_res_d, rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic            regw_q, regw_d, memr_q, memr_d;
  logic            memw_q, memw_d, memtoreg_q, memtoreg_d;

  function automatic logic br_cond(input logic [2:0] f3,
                                   input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic r;
    case (f3)
      BR_BEQ:  r = (a == b);
      BR_BNE:  r = (a != b);
      BR_BLT:  r = ($signed(a) < $signed(b));
      BR_BGE:  r = ($signed(a) >= $signed(b));
      BR_BLTU: r = (a < b);
      BR_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Forwarding muxes; the unused code 2'b11 falls back to register-file data.
  always_comb begin
    case (Mux_A)
      FWD_MEM: fwd_a_s = alu_res_q;
      FWD_WB:  fwd_a_s = MEM_WB_WriteData;
      default: fwd_a_s = ID_EX_Rs1Data;
    endcase
    case (Mux_B)
      FWD_MEM: fwd_b_s = alu_res_q;
      FWD_WB:  fwd_b_s = MEM_WB_WriteData;
      default: fwd_b_s = ID_EX_Rs2Data;
    endcase
  end

  assign opa_s   = ID_EX_AluSrcA ? ID_EX_Pc : fwd_a_s;
  assign opb_s   = ID_EX_AluSrcB ? ID_EX_Imm : fwd_b_s;
  assign shamt_s = opb_s[SW-1:0];

  // ALU; MUL-class ops take the multiplier output (0 when it is not built).
  always_comb begin
    case (ID_EX_AluOp)
      ALU_ADD:   alu_res_s = opa_s + opb_s;
      ALU_SUB:   alu_res_s = opa_s - opb_s;
      ALU_SLL:   alu_res_s = opa_s << shamt_s;
      ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
      ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (opa_s < opb_s)};
      ALU_XOR:   alu_res_s = opa_s ^ opb_s;
      ALU_SRL:   alu_res_s = opa_s >> shamt_s;
      ALU_SRA:   alu_res_s = $unsigned($signed(opa_s) >>> shamt_s);
      ALU_OR:    alu_res_s = opa_s | opb_s;
      ALU_AND:   alu_res_s = opa_s & opb_s;
      ALU_PASSB: alu_res_s = opb_s;
      ALU_MUL, ALU_MULH, ALU_MULHU: alu_res_s = mul_res_s;
      default:   alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Jumps write the link address instead of the ALU result.
  always_comb begin
    if (ID_EX_Jal || ID_EX_Jalr) begin
      ex_res_s = ID_EX_Pc + XLEN'(4);
    end else begin
      ex_res_s = alu_res_s;
    end
  end

  // Redirect uses forwarded rs1 for JALR, never the ALU's operand A mux.
  assign jalr_sum_s = fwd_a_s + ID_EX_Imm;
  assign br_target  = ID_EX_Jalr ? {jalr_sum_s[XLEN-1:1], 1'b0} : (ID_EX_Pc + ID_EX_Imm);
  assign br_taken   = ID_EX_Valid && !ex_flush &&
                      (ID_EX_Jal || ID_EX_Jalr ||
                       (ID_EX_Branch && br_cond(ID_EX_BrCond, fwd_a_s, fwd_b_s)));

`ifdef RV_MUL_EN
  ex_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (ID_EX_Valid && is_mul_op(ID_EX_AluOp) && !ex_flush),
    .op        (ID_EX_AluOp),
    .a         (fwd_a_s),
    .b         (fwd_b_s),
    .mem_stall (mem_stall),
    .ex_flush  (ex_flush),
    .busy      (ex_busy_s),
    .result    (mul_res_s)
  );
`else
  assign ex_busy_s = 1'b0;
  assign mul_res_s = {XLEN{1'b0}};
  // MUL_CYCLES only matters to the multiplier; it must track XLEN so that the
  // shift-add loop consumes every multiplier bit. The empty block below just
  // marks a mismatched configuration in the elaborated hierarchy.
  if (MUL_CYCLES != XLEN) begin : g_mul_cycles_ne_xlen
  end
`endif

  assign ex_busy = ex_busy_s;

  // EX/MEM load priority: flush bubble, stall hold, busy bubble, normal load.
  always_comb begin
    alu_res_d  = alu_res_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    memr_d     = memr_q;
    memw_d     = memw_q;
    memtoreg_d = memtoreg_q;
    if (ex_flush || (!mem_stall && ex_busy_s)) begin
      regw_d     = 1'b0;
      memr_d     = 1'b0;
      memw_d     = 1'b0;
      memtoreg_d = 1'b0;
    end else if (mem_stall) begin
      regw_d = regw_q;
    end else begin
      alu_res_d  = ex_res_s;
      rs2_d      = fwd_b_s;
      rd_d       = ID_EX_RegRd;
      regw_d     = ID_EX_RegW     && ID_EX_Valid;
      memr_d     = ID_EX_MemR     && ID_EX_Valid;
      memw_d     = ID_EX_MemW     && ID_EX_Valid;
      memtoreg_d = ID_EX_MemToReg && ID_EX_Valid;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res_q  <= {XLEN{1'b0}};
      rs2_q      <= {XLEN{1'b0}};
      rd_q       <= 5'd0;
      regw_q     <= 1'b0;
      memr_q     <= 1'b0;
      memw_q     <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      alu_res_q  <= alu_res_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      memr_q     <= memr_d;
      memw_q     <= memw_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  assign EX_MEM_AluResult = alu_res_q;
  assign EX_MEM_Rs2Data   = rs2_q;
  assign EX_MEM_RegRd     = rd_q;
  assign EX_MEM_RegW      = regw_q;
  assign EX_MEM_MemR      = memr_q;
  assign EX_MEM_MemW      = memw_q;
  assign EX_MEM_MemToReg  = memtoreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, scoreboard-checked bench for ex_stage (XLEN=32).
// Expected EX/MEM contents are queued when an instruction is driven and
// compared after the clock edge that should capture it. Multiplier timing is
// exercised only when RV_MUL_EN is defined.
module tb_ex_stage;
  import rv_ex_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ID_EX_Valid;
  logic [31:0] ID_EX_Pc, ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm;
  logic [3:0]  ID_EX_AluOp;
  logic        ID_EX_AluSrcA, ID_EX_AluSrcB;
  logic        ID_EX_Branch, ID_EX_Jal, ID_EX_Jalr;
  logic [2:0]  ID_EX_BrCond;
  logic        ID_EX_RegW, ID_EX_MemR, ID_EX_MemW, ID_EX_MemToReg;
  logic [4:0]  ID_EX_RegRd;
  logic [1:0]  Mux_A, Mux_B;
  logic [31:0] MEM_WB_WriteData;
  logic        mem_stall, ex_flush;
  logic [31:0] EX_MEM_AluResult, EX_MEM_Rs2Data;
  logic [4:0]  EX_MEM_RegRd;
  logic        EX_MEM_RegW, EX_MEM_MemR, EX_MEM_MemW, EX_MEM_MemToReg;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ex_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .ID_EX_Valid(ID_EX_Valid), .ID_EX_Pc(ID_EX_Pc),
    .ID_EX_Rs1Data(ID_EX_Rs1Data), .ID_EX_Rs2Data(ID_EX_Rs2Data), .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_AluOp(ID_EX_AluOp), .ID_EX_AluSrcA(ID_EX_AluSrcA), .ID_EX_AluSrcB(ID_EX_AluSrcB),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jal(ID_EX_Jal), .ID_EX_Jalr(ID_EX_Jalr),
    .ID_EX_BrCond(ID_EX_BrCond), .ID_EX_RegW(ID_EX_RegW), .ID_EX_MemR(ID_EX_MemR),
    .ID_EX_MemW(ID_EX_MemW), .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_RegRd(ID_EX_RegRd),
    .Mux_A(Mux_A), .Mux_B(Mux_B), .MEM_WB_WriteData(MEM_WB_WriteData),
    .mem_stall(mem_stall), .ex_flush(ex_flush),
    .EX_MEM_AluResult(EX_MEM_AluResult), .EX_MEM_Rs2Data(EX_MEM_Rs2Data),
    .EX_MEM_RegRd(EX_MEM_RegRd), .EX_MEM_RegW(EX_MEM_RegW), .EX_MEM_MemR(EX_MEM_MemR),
    .EX_MEM_MemW(EX_MEM_MemW), .EX_MEM_MemToReg(EX_MEM_MemToReg),
    .br_taken(br_taken), .br_target(br_target), .ex_busy(ex_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  ctl;   // {RegW, MemR, MemW, MemToReg}
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] res, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [3:0] ctl);
    exp_t e;
    e.tag = tag; e.res = res; e.rs2 = rs2; e.rd = rd; e.ctl = ctl;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 queued entries expected at least 1");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".res"}, EX_MEM_AluResult, e.res);
      check({e.tag, ".rs2"}, EX_MEM_Rs2Data, e.rs2);
      check({e.tag, ".rd"},  {27'd0, EX_MEM_RegRd}, {27'd0, e.rd});
      check({e.tag, ".ctl"}, {28'd0, EX_MEM_RegW, EX_MEM_MemR, EX_MEM_MemW, EX_MEM_MemToReg},
            {28'd0, e.ctl});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ID_EX_Valid = 1'b1; ID_EX_Pc = 32'd0; ID_EX_Rs1Data = 32'd0; ID_EX_Rs2Data = 32'd0;
    ID_EX_Imm = 32'd0; ID_EX_AluOp = ALU_ADD; ID_EX_AluSrcA = 1'b0; ID_EX_AluSrcB = 1'b0;
    ID_EX_Branch = 1'b0; ID_EX_Jal = 1'b0; ID_EX_Jalr = 1'b0; ID_EX_BrCond = 3'b000;
    ID_EX_RegW = 1'b1; ID_EX_MemR = 1'b0; ID_EX_MemW = 1'b0; ID_EX_MemToReg = 1'b0;
    ID_EX_RegRd = 5'd1; Mux_A = 2'b00; Mux_B = 2'b00; MEM_WB_WriteData = 32'd0;
    mem_stall = 1'b0; ex_flush = 1'b0;
  endtask

  // ALU table: op, A (rs1), B (rs2), expected result
  localparam int NT = 13;
  logic [3:0]  t_op  [NT] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
                              ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, 4'hE, 4'hF};
  logic [31:0] t_a   [NT] = '{32'h7FFFFFFF, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hF0F0F0F0, 32'h80000000, 32'h80000000, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'h12345678, 32'h5, 32'h5};
  logic [31:0] t_b   [NT] = '{32'h1, 32'h1, 32'h23, 32'h1, 32'h1, 32'hFF00FF00, 32'h4,
                              32'h4, 32'h0F0F0000, 32'hFF00FF00, 32'hABCDE000, 32'h6, 32'h6};
  logic [31:0] t_exp [NT] = '{32'h80000000, 32'hFFFFFFFF, 32'h8, 32'h1, 32'h0, 32'h0FF00FF0,
                              32'h08000000, 32'hF8000000, 32'hFFFFF0F0, 32'hF000F000,
                              32'hABCDE000, 32'h0, 32'h0};

  // Branch table: funct3, rs1, rs2, valid, expected br_taken (PC=0x100, Imm=0x20)
  localparam int NB = 8;
  logic [2:0]  b_f3  [NB] = '{BR_BLT, BR_BLTU, BR_BGE, BR_BGEU, BR_BEQ, BR_BNE, 3'b010, BR_BEQ};
  logic [31:0] b_a   [NB] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h5, 32'h5, 32'h5, 32'h5};
  logic [31:0] b_b   [NB] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h5, 32'h5, 32'h5, 32'h5};
  logic        b_v   [NB] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        b_exp [NB] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

`ifdef RV_MUL_EN
  // Runs one MUL-class op; mem_stall is held for 4 cycles from stall_from.
  // exp_busy is the number of cycles ex_busy must stay high (== DONE cycle index).
  task automatic run_mul(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int stall_from, input int exp_busy);
    int busy_cycles;
    bit done_seen;
    busy_cycles = 0;
    done_seen = 1'b0;
    clear_in();
    ID_EX_AluOp = op; ID_EX_Rs1Data = a; ID_EX_Rs2Data = b; ID_EX_RegRd = 5'd7;
    for (int i = 0; i < 100; i++) begin
      mem_stall = (i >= stall_from) && (i < stall_from + 4);
      // Forward source changes after issue must not disturb the captured operand.
      if (i == 3) begin
        Mux_A = FWD_WB;
        MEM_WB_WriteData = 32'h0;
      end
      #1;
      if (!ex_busy) begin
        done_seen = 1'b1;
        break;
      end
      busy_cycles++;
      tick();
      check({tag, ".bubble_regw"}, {31'd0, EX_MEM_RegW}, 32'd0);
    end
    check({tag, ".done_seen"}, {31'd0, done_seen}, 32'd1);
    check({tag, ".busy_cycles"}, busy_cycles, exp_busy);
    mem_stall = 1'b0;
    Mux_A = FWD_RF;
    sb_push(tag, exp_res, b, 5'd7, 4'b1000);
    tick();
    sb_check();
  endtask
`endif

  initial begin
    clear_in();
    ID_EX_Valid = 1'b0;
    rst_n = 1'b0;
    #12;
    check("reset.res", EX_MEM_AluResult, 32'd0);
    check("reset.rs2", EX_MEM_Rs2Data, 32'd0);
    check("reset.ctl", {27'd0, EX_MEM_RegRd, EX_MEM_RegW, EX_MEM_MemR, EX_MEM_MemW,
                        EX_MEM_MemToReg}, 32'd0);
    check("reset.busy", {31'd0, ex_busy}, 32'd0);
    check("reset.br_taken", {31'd0, br_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Forwarding priority: first produce 5 in EX/MEM, then forward it.
    clear_in(); ID_EX_Rs1Data = 32'd2; ID_EX_Imm = 32'd3; ID_EX_AluSrcB = 1'b1; ID_EX_RegRd = 5'd5;
    sb_push("fwd.seed", 32'd5, 32'd0, 5'd5, 4'b1000); tick(); sb_check();
    clear_in(); Mux_A = 2'b10; MEM_WB_WriteData = 32'd9; ID_EX_Rs1Data = 32'd1;
    ID_EX_Imm = 32'd3; ID_EX_AluSrcB = 1'b1;
    sb_push("fwd.mem", 32'd8, 32'd0, 5'd1, 4'b1000); tick(); sb_check();
    clear_in(); Mux_A = 2'b11; MEM_WB_WriteData = 32'd9; ID_EX_Rs1Data = 32'd1;
    ID_EX_Imm = 32'd3; ID_EX_AluSrcB = 1'b1;
    sb_push("fwd.sel11", 32'd4, 32'd0, 5'd1, 4'b1000); tick(); sb_check();
    clear_in(); Mux_A = 2'b01; MEM_WB_WriteData = 32'd9; ID_EX_Rs1Data = 32'd1;
    ID_EX_Imm = 32'd3; ID_EX_AluSrcB = 1'b1;
    sb_push("fwd.wb", 32'd12, 32'd0, 5'd1, 4'b1000); tick(); sb_check();
    // Operand B from EX/MEM (12): 20 - 12; store data is the forwarded B.
    clear_in(); ID_EX_AluOp = ALU_SUB; ID_EX_Rs1Data = 32'd20; ID_EX_Rs2Data = 32'd99; Mux_B = 2'b10;
    sb_push("fwd.b_mem", 32'd8, 32'd12, 5'd1, 4'b1000); tick(); sb_check();
    // Store: address rs1+imm, data forwarded from WB.
    clear_in(); ID_EX_Rs1Data = 32'h1000; ID_EX_Imm = 32'd8; ID_EX_AluSrcB = 1'b1;
    ID_EX_Rs2Data = 32'h1111; Mux_B = 2'b01; MEM_WB_WriteData = 32'hABCD;
    ID_EX_RegW = 1'b0; ID_EX_MemW = 1'b1; ID_EX_RegRd = 5'd0;
    sb_push("store", 32'h1008, 32'hABCD, 5'd0, 4'b0010); tick(); sb_check();
    // AUIPC-style: A = PC.
    clear_in(); ID_EX_Pc = 32'h400; ID_EX_AluSrcA = 1'b1; ID_EX_Imm = 32'h1000;
    ID_EX_AluSrcB = 1'b1; ID_EX_MemR = 1'b1; ID_EX_MemToReg = 1'b1; ID_EX_RegRd = 5'd4;
    sb_push("auipc", 32'h1400, 32'd0, 5'd4, 4'b1101); tick(); sb_check();

    for (int i = 0; i < NT; i++) begin
      clear_in(); ID_EX_AluOp = t_op[i]; ID_EX_Rs1Data = t_a[i]; ID_EX_Rs2Data = t_b[i];
      ID_EX_RegRd = 5'(i + 2);
      sb_push($sformatf("alu%0d", i), t_exp[i], t_b[i], 5'(i + 2), 4'b1000);
      tick(); sb_check();
    end

    // Invalid instruction: data still loads, control bits are cleared.
    clear_in(); ID_EX_Valid = 1'b0; ID_EX_Rs1Data = 32'd1; ID_EX_Rs2Data = 32'd1;
    ID_EX_MemR = 1'b1; ID_EX_RegRd = 5'd3;
    sb_push("invalid", 32'd2, 32'd1, 5'd3, 4'b0000); tick(); sb_check();

    for (int i = 0; i < NB; i++) begin
      clear_in(); ID_EX_Branch = 1'b1; ID_EX_RegW = 1'b0; ID_EX_BrCond = b_f3[i];
      ID_EX_Rs1Data = b_a[i]; ID_EX_Rs2Data = b_b[i]; ID_EX_Valid = b_v[i];
      ID_EX_Pc = 32'h100; ID_EX_Imm = 32'h20;
      #1;
      check($sformatf("br%0d.taken", i), {31'd0, br_taken}, {31'd0, b_exp[i]});
      check($sformatf("br%0d.target", i), br_target, 32'h120);
      tick();
    end

    // JALR: target (rs1+imm) with bit 0 cleared; link PC+4.
    clear_in(); ID_EX_Jalr = 1'b1; ID_EX_Rs1Data = 32'h1003; ID_EX_Imm = 32'd2;
    ID_EX_Pc = 32'h40; ID_EX_AluSrcB = 1'b1;
    #1;
    check("jalr.taken", {31'd0, br_taken}, 32'd1);
    check("jalr.target", br_target, 32'h1004);
    sb_push("jalr", 32'h44, 32'd0, 5'd1, 4'b1000); tick(); sb_check();
    clear_in(); ID_EX_Jal = 1'b1; ID_EX_Pc = 32'h200; ID_EX_Imm = 32'h10;
    #1;
    check("jal.taken", {31'd0, br_taken}, 32'd1);
    check("jal.target", br_target, 32'h210);
    sb_push("jal", 32'h204, 32'd0, 5'd1, 4'b1000); tick(); sb_check();

    // Flush: no redirect, bubble with previous data kept.
    clear_in(); ID_EX_Jal = 1'b1; ID_EX_Rs1Data = 32'd7; ID_EX_Imm = 32'd1;
    ID_EX_AluSrcB = 1'b1; ID_EX_RegRd = 5'd9; ex_flush = 1'b1;
    #1;
    check("flush.taken", {31'd0, br_taken}, 32'd0);
    sb_push("flush", 32'h204, 32'd0, 5'd1, 4'b0000); tick(); sb_check();
    // Stall holds EX/MEM, then the same op loads once released.
    clear_in(); ID_EX_Rs1Data = 32'd7; ID_EX_Imm = 32'd1; ID_EX_AluSrcB = 1'b1;
    ID_EX_RegRd = 5'd3; mem_stall = 1'b1;
    sb_push("stall.hold", 32'h204, 32'd0, 5'd1, 4'b0000); tick(); sb_check();
    mem_stall = 1'b0;
    sb_push("stall.release", 32'd8, 32'd0, 5'd3, 4'b1000); tick(); sb_check();

`ifdef RV_MUL_EN
    run_mul("mulh_stall", ALU_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 5, 37);
    run_mul("mul", ALU_MUL, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1000, 33);
    run_mul("mulhu", ALU_MULHU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 1000, 33);
    run_mul("mulh_min", ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1000, 33);

    // Flush at N+10 aborts; ex_busy low at N+11; no RegW pulse.
    clear_in(); ID_EX_AluOp = ALU_MUL; ID_EX_Rs1Data = 32'd5; ID_EX_Rs2Data = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mflush.regw", {31'd0, EX_MEM_RegW}, 32'd0);
    end
    ex_flush = 1'b1;
    tick();
    check("mflush.regw_flush", {31'd0, EX_MEM_RegW}, 32'd0);
    ex_flush = 1'b0; ID_EX_Valid = 1'b0;
    #1;
    check("mflush.busy_n11", {31'd0, ex_busy}, 32'd0);
    tick();
    check("mflush.regw_after", {31'd0, EX_MEM_RegW}, 32'd0);
`else
    // Without the multiplier MUL-class ops give 0 and never stall.
    clear_in(); ID_EX_AluOp = ALU_MULH; ID_EX_Rs1Data = 32'hFFFFFFFE; ID_EX_Rs2Data = 32'd3;
    #1;
    check("nomul.busy", {31'd0, ex_busy}, 32'd0);
    sb_push("nomul.mulh", 32'd0, 32'd3, 5'd1, 4'b1000); tick(); sb_check();
`endif

    // Asynchronous reset between edges, then normal operation resumes.
    clear_in(); ID_EX_Rs1Data = 32'h50; ID_EX_Imm = 32'd5; ID_EX_AluSrcB = 1'b1; ID_EX_MemR = 1'b1;
    sb_push("pre_rst", 32'h55, 32'd0, 5'd1, 4'b1100); tick(); sb_check();
`ifdef RV_MUL_EN
    clear_in(); ID_EX_AluOp = ALU_MUL; ID_EX_Rs1Data = 32'd3; ID_EX_Rs2Data = 32'd4;
    for (int i = 0; i < 5; i++) tick();
    check("rst.busy_before", {31'd0, ex_busy}, 32'd1);
`endif
    #2;
    rst_n = 1'b0; ID_EX_Valid = 1'b0;
    #1;
    check("rst.res", EX_MEM_AluResult, 32'd0);
    check("rst.ctl", {27'd0, EX_MEM_RegRd, EX_MEM_RegW, EX_MEM_MemR, EX_MEM_MemW,
                      EX_MEM_MemToReg}, 32'd0);
    check("rst.busy", {31'd0, ex_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in(); ID_EX_Rs1Data = 32'd1; ID_EX_Rs2Data = 32'd2; ID_EX_RegRd = 5'd6;
    sb_push("post_rst", 32'd3, 32'd2, 5'd6, 4'b1000); tick(); sb_check();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline, between the ID/EX register and the MEM stage. Applies the forwarding-unit selects to both operands, runs the ALU, resolves branches and jumps, and owns the EX/MEM pipeline register. An optional iterative multiplier stalls the front end while a MUL-class op completes.

## Interface
- Parameters: XLEN, default 32, datapath width; MUL_CYCLES, default 32, multiplier iteration count (must equal XLEN).
- Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- ID_EX_Valid  in  1  the ID/EX register holds a real instruction
- ID_EX_Pc, ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm  in  XLEN  register-file operands, PC, and sign-extended immediate
- ID_EX_AluOp  in  4  operation code from the shared package
- ID_EX_AluSrcA / ID_EX_AluSrcB  in  1  select operand A as PC / operand B as Imm
- ID_EX_Branch, ID_EX_Jal, ID_EX_Jalr  in  1  control-transfer type
- ID_EX_BrCond  in  3  funct3 branch condition
- ID_EX_RegW, ID_EX_MemR, ID_EX_MemW, ID_EX_MemToReg  in  1  control bits passed to later stages
- ID_EX_RegRd  in  5  destination register
- Mux_A, Mux_B  in  2  forwarding selects
- MEM_WB_WriteData  in  XLEN  writeback value, used as the forward source
- mem_stall  in  1  freeze the EX/MEM register and the multiplier
- ex_flush  in  1  kill the instruction currently in EX
- EX_MEM_AluResult, EX_MEM_Rs2Data  out  XLEN  result, and store data after forwarding
- EX_MEM_RegRd  out  5; EX_MEM_RegW, EX_MEM_MemR, EX_MEM_MemW, EX_MEM_MemToReg  out  1
- br_taken  out  1; br_target  out  XLEN  redirect request, combinational
- ex_busy  out  1  hold the IF, ID and ID/EX stages

## Operation
- Forwarding select, per operand:
  - 2'b10 selects EX_MEM_AluResult.
  - 2'b01 selects MEM_WB_WriteData.
  - 2'b00 and 2'b11 select the register-file data.
  - fwdA and fwdB are the selected values.
- Operand A is fwdA, or ID_EX_Pc if AluSrcA is set. Operand B is fwdB, or ID_EX_Imm if AluSrcB is set.
- ALU ops:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, A PASSB (LUI).
  - B MUL, C MULH, D MULHU.
  - E and F are reserved and give 0.
  - Shift amount is B[4:0]. All arithmetic wraps modulo 2^XLEN.
- Jal or Jalr: the result is PC+4.
- br_target:
  - Jalr gives (fwdA+Imm) & ~1.
  - Otherwise it is PC+Imm.
- br_taken = ID_EX_Valid & !ex_flush & (Jal | Jalr | (Branch & cond(fwdA, fwdB))).
- Branch conditions: BEQ, BNE, BLT, BGE, BLTU, BGEU. Other funct3 values are not taken.
- EX/MEM register, in priority order at each edge:
  1. Reset: all outputs 0.
  2. ex_flush: load a bubble (every control bit 0; data unchanged).
  3. mem_stall: hold.
  4. ex_busy: load a bubble.
  5. Otherwise: load the EX values, with control bits ANDed with ID_EX_Valid.
- Multiplier FSM (RV_MUL_EN only):
  - IDLE: a valid MUL-class op with no flush and no stall latches |A|, |B|, sign fixups and the op, then moves to BUSY with cnt=0.
  - BUSY: one shift-add step per cycle. At cnt==MUL_CYCLES-1, moves to DONE.
  - DONE: drives the signed-corrected product (low half for MUL, high half for MULH/MULHU), then returns to IDLE.
  - mem_stall freezes the FSM in any state.
  - ex_flush forces IDLE from any state.
- ex_busy = (IDLE & valid MUL op & !ex_flush) | BUSY. It is low in DONE.

## Timing
- ALU, branch and jump ops: results appear in EX/MEM one edge after the op enters EX. br_taken is valid in that same cycle.
- MUL op entering EX in cycle N:
  - ex_busy is high for cycles N..N+32.
  - DONE occurs in cycle N+33.
  - The result appears in EX/MEM after the edge that ends N+33. ID/EX advances at that same edge.
- Operands are captured at issue. Forward sources draining during the stall do not affect the result.
- Flush during BUSY aborts the op: no write to EX/MEM, and ex_busy drops in the next cycle.
- Reset values: EX/MEM outputs 0, FSM IDLE, cnt 0, ex_busy 0.

## Configuration
- RV_MUL_EN defined: the multiplier and FSM are present, as described above.
- RV_MUL_EN undefined: no multiplier logic is built. Ops B–D give 0, and ex_busy is tied to 0.

## Structure
- Shared package rv_ex_pkg holds:
  - ALU op codes;
  - branch funct3 constants;
  - forward-select codes (FWD_RF, FWD_WB, FWD_MEM);
  - multiplier state enum.
- One sub-module, ex_mul_iter: the FSM, counter and shift-add datapath. It is instantiated only under RV_MUL_EN.

## Test plan
- Forward priority:
  - Stimulus: Mux_A=10, EX_MEM_AluResult=5, MEM_WB_WriteData=9, Rs1Data=1, ADD with B=Imm=3.
  - Required: EX_MEM_AluResult=8. With Mux_A=11, the result is 4.
- Branch:
  - Stimulus: BLT, fwdA=0xFFFFFFFF, fwdB=1, PC=0x100, Imm=0x20.
  - Required: br_taken=1, br_target=0x120.
  - With BLTU and the same operands: br_taken=0.
- JALR:
  - Stimulus: fwdA=0x1003, Imm=2, PC=0x40.
  - Required: br_target=0x1004, EX_MEM_AluResult=0x44.
- MULH with mem_stall:
  - Stimulus: MULH of 0xFFFFFFFE by 3; mem_stall pulsed for 4 cycles during BUSY.
  - Required: result 0xFFFFFFFF, delivered at N+38; ex_busy high for exactly 37 cycles; EX/MEM holds bubbles meanwhile.
- Flush mid-multiply: ex_flush asserted at N+10 → FSM returns to IDLE, ex_busy=0 at N+11, no RegW pulse.
- Async reset: rst_n asserted mid-BUSY → all outputs 0 immediately; the next op after release executes normally.
